wb_align_unit: RTL and testbench

WB_ALIGN_UNIT -- requirements
Module: wb_align_unit

---
 rtl/wb_pkg.sv | 51 +++++
 rtl/wb_load_align.sv | 56 +++++
 rtl/wb_align_unit.sv | 155 +++++++++++++++
 tb/tb_wb_align_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg -- shared definitions for the write-back alignment unit.
//
// Contents:
//   - access size encodings (B/H/W/D)
//   - the MSTATUS CSR address and FS/XS field positions used to derive SD
//   - wb_entry_t, the record stored per FIFO entry
//
// Optional macro WB_DIFFTEST_EN adds pc/inst/skip fields to wb_entry_t.
//
// The entry record is sized for the widest legal configuration
// (XLEN = 64, CSR_AW = 12); narrower builds use the low bits only.
package wb_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [11:0] MSTATUS_ADDR = 12'h300;

  // mstatus field positions. SD lives in the top bit, so its position is
  // XLEN-1 and is applied by the user of this package.
  localparam int FS_LO = 13;
  localparam int FS_HI = 14;
  localparam int XS_LO = 15;
  localparam int XS_HI = 16;

  localparam int ENTRY_XLEN = 64;
  localparam int ENTRY_AW   = 12;

  typedef struct packed {
    logic [4:0]            wa;
    logic                  wreg;
    logic [ENTRY_XLEN-1:0] wd;
    logic                  misalign;
    logic                  csr_we;
    logic [ENTRY_AW-1:0]   csr_waddr;
    logic [ENTRY_XLEN-1:0] csr_wdata;
`ifdef WB_DIFFTEST_EN
    logic [ENTRY_XLEN-1:0] pc;
    logic [31:0]           inst;
    logic                  skip;
`endif
  } wb_entry_t;

  // SD summarises "some extension state is dirty".
  function automatic logic sd_bit(input logic [1:0] fs, input logic [1:0] xs);
    return (fs == 2'b11) || (xs == 2'b11);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align -- combinational load-data extraction and misalign check.
//
// Ports:
//   dm       in  XLEN  raw memory word
//   offset   in  OW    byte address low bits (OW = log2(XLEN/8))
//   size     in  2     0 = B, 1 = H, 2 = W, 3 = D
//   sign     in  1     1 = sign-extend, 0 = zero-extend
//   data     out XLEN  extracted and extended load value
//   misalign out 1     offset not a multiple of the access size, or a
//                      doubleword access on a 32-bit datapath
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]             dm,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [1:0]                  size,
  input  logic                        sign,
  output logic [XLEN-1:0]             data,
  output logic                        misalign
);

  localparam int OW = $clog2(XLEN/8);

  logic [XLEN-1:0] shifted;
  logic [OW-1:0]   align_mask;

  always_comb begin
    shifted    = dm >> {offset, 3'b000};
    data       = '0;
    align_mask = '0;
    // A size cast of a signed operand sign-extends, so each lane is one
    // expression regardless of XLEN.
    case (size)
      SIZE_B: begin
        data       = sign ? XLEN'($signed(shifted[7:0])) : XLEN'(shifted[7:0]);
        align_mask = OW'(0);
      end
      SIZE_H: begin
        data       = sign ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
        align_mask = OW'(1);
      end
      SIZE_W: begin
        data       = sign ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
        align_mask = OW'(3);
      end
      default: begin
        data       = shifted;
        align_mask = OW'(7);
      end
    endcase
    misalign = (|(offset & align_mask)) || ((size == SIZE_D) && (XLEN == 32));
  end

endmodule

// File: rtl/wb_align_unit.sv
// wb_align_unit -- write-back stage: load alignment, CSR write fix-up and a
// small output FIFO toward the register file / CSR file.
//
// Parameters: XLEN (32/64), DEPTH (2..8 FIFO entries), CSR_AW (<= 12).
// Optional macro WB_DIFFTEST_EN adds in_pc/in_inst/in_skip and
// wb_pc/wb_inst/wb_skip, carried through the FIFO with each entry.
//
// Ports:
//   clock, reset (synchronous, active-high)
//   in_*   entry from the memory stage: dest reg, ALU result, load controls,
//          CSR write request; dm is the raw memory word
//   flush  drops every buffered entry and any push in the same cycle
//   wb_*   register write-back head of FIFO; csr_* CSR write head of FIFO
//
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high. in_ready is high when the FIFO has room or the head is leaving
// in the same cycle; a producer may not withdraw or change an offered entry
// until it is taken. While wb_valid is high and wb_ready low the head and
// all wb_*/csr_* outputs stay put. With wb_valid low every output is zero.
module wb_align_unit
  import wb_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 2,
  parameter int CSR_AW = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_wa,
  input  logic                       in_wreg,
  input  logic [XLEN-1:0]            in_dreg,
  input  logic                       in_mreg,
  input  logic [1:0]                 in_size,
  input  logic                       in_sign,
  input  logic [$clog2(XLEN/8)-1:0]  in_offset,
  input  logic [XLEN-1:0]            dm,
  input  logic                       in_csr_we,
  input  logic [CSR_AW-1:0]          in_csr_waddr,
  input  logic [XLEN-1:0]            in_csr_wdata,
  input  logic                       flush,
`ifdef WB_DIFFTEST_EN
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  input  logic                       in_skip,
  output logic [XLEN-1:0]            wb_pc,
  output logic [31:0]                wb_inst,
  output logic                       wb_skip,
`endif
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [4:0]                 wb_wa,
  output logic                       wb_wreg,
  output logic [XLEN-1:0]            wb_wd,
  output logic                       wb_misalign,
  output logic                       csr_we,
  output logic [CSR_AW-1:0]          csr_waddr,
  output logic [XLEN-1:0]            csr_wdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  wb_entry_t       push_e;
  wb_entry_t       head_e;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] ld_data;
  logic            ld_misalign;
  logic [XLEN-1:0] csr_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .dm       (dm),
    .offset   (in_offset),
    .size     (in_size),
    .sign     (in_sign),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  assign wb_valid = (count != '0);
  assign pop      = wb_valid && wb_ready;
  // Gating with reset keeps a transfer from being taken in a reset cycle.
  assign in_ready = !reset && ((count < CW'(DEPTH)) || pop);
  assign push     = in_valid && in_ready && !flush;

  // Entry is fully formed at accept time so the FIFO only moves data.
  always_comb begin
    push_e          = '0;
    push_e.wa       = in_wa;
    push_e.misalign = ld_misalign;
    push_e.wreg     = in_wreg && (in_wa != 5'd0) && !ld_misalign;
    push_e.wd[XLEN-1:0] = in_mreg ? ld_data : in_dreg;
    push_e.csr_we   = in_csr_we;
    push_e.csr_waddr[CSR_AW-1:0] = in_csr_waddr;
    csr_d = in_csr_wdata;
    if (in_csr_we && (in_csr_waddr == CSR_AW'(MSTATUS_ADDR))) begin
      csr_d[XLEN-1] = sd_bit(in_csr_wdata[FS_HI:FS_LO], in_csr_wdata[XS_HI:XS_LO]);
    end
    push_e.csr_wdata[XLEN-1:0] = csr_d;
`ifdef WB_DIFFTEST_EN
    push_e.pc[XLEN-1:0] = in_pc;
    push_e.inst         = in_inst;
    push_e.skip         = in_skip;
`endif
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_e;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; an empty FIFO presents an all-zero head instead.
  assign head_e = wb_valid ? mem[rd_ptr] : '0;

  assign wb_wa       = head_e.wa;
  assign wb_wreg     = head_e.wreg;
  assign wb_wd       = head_e.wd[XLEN-1:0];
  assign wb_misalign = head_e.misalign;
  assign csr_we      = head_e.csr_we;
  assign csr_waddr   = head_e.csr_waddr[CSR_AW-1:0];
  assign csr_wdata   = head_e.csr_wdata[XLEN-1:0];
`ifdef WB_DIFFTEST_EN
  assign wb_pc   = head_e.pc[XLEN-1:0];
  assign wb_inst = head_e.inst;
  assign wb_skip = head_e.skip;
`endif

endmodule

// File: tb/tb_wb_align_unit.sv
// tb_wb_align_unit -- bench for wb_align_unit (XLEN = 64, DEPTH = 2).
module tb_wb_align_unit;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 2;
  localparam int CSR_AW = 12;
  localparam int W      = 5 + 1 + 64 + 1 + 1 + 12 + 64;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              in_valid = 0;
  logic              in_ready;
  logic [4:0]        in_wa = 0;
  logic              in_wreg = 0;
  logic [63:0]       in_dreg = 0;
  logic              in_mreg = 0;
  logic [1:0]        in_size = 0;
  logic              in_sign = 0;
  logic [2:0]        in_offset = 0;
  logic [63:0]       dm = 0;
  logic              in_csr_we = 0;
  logic [11:0]       in_csr_waddr = 0;
  logic [63:0]       in_csr_wdata = 0;
  logic              flush = 0;
  logic              wb_valid;
  logic              wb_ready = 0;
  logic [4:0]        wb_wa;
  logic              wb_wreg;
  logic [63:0]       wb_wd;
  logic              wb_misalign;
  logic              csr_we;
  logic [11:0]       csr_waddr;
  logic [63:0]       csr_wdata;

  wb_align_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CSR_AW(CSR_AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wa        (in_wa),
    .in_wreg      (in_wreg),
    .in_dreg      (in_dreg),
    .in_mreg      (in_mreg),
    .in_size      (in_size),
    .in_sign      (in_sign),
    .in_offset    (in_offset),
    .dm           (dm),
    .in_csr_we    (in_csr_we),
    .in_csr_waddr (in_csr_waddr),
    .in_csr_wdata (in_csr_wdata),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_wa        (wb_wa),
    .wb_wreg      (wb_wreg),
    .wb_wd        (wb_wd),
    .wb_misalign  (wb_misalign),
    .csr_we       (csr_we),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata)
  );

  // scoreboard state
  int         total = 0;
  int         bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [W-1:0] hold_val;
  logic         hold_v   = 0;
  logic         exp_rdy;
  logic         rand_rdy = 0;

  assign obs = {wb_wa, wb_wreg, wb_wd, wb_misalign, csr_we, csr_waddr, csr_wdata};

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of one accepted entry, from the current inputs.
  function automatic logic [W-1:0] model();
    logic [63:0] sh;
    logic [63:0] ld;
    logic [63:0] cd;
    logic        mis;
    logic        wr;
    int          nb;
    sh = dm >> (int'(in_offset) * 8);
    case (in_size)
      2'd0:    ld = in_sign ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
      2'd1:    ld = in_sign ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
      2'd2:    ld = in_sign ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
      default: ld = sh;
    endcase
    nb  = 1 << in_size;
    mis = (int'(in_offset) % nb) != 0;
    wr  = in_wreg && (in_wa != 5'd0) && !mis;
    cd  = in_csr_wdata;
    if (in_csr_we && (in_csr_waddr == 12'h300))
      cd[63] = (in_csr_wdata[14:13] == 2'b11) || (in_csr_wdata[16:15] == 2'b11);
    return {in_wa, wr, (in_mreg ? ld : in_dreg), mis, in_csr_we, in_csr_waddr, cd};
  endfunction

  // Monitor: samples at the falling edge, inputs only change just after the
  // rising edge.
  always @(negedge clock) begin
    if (reset) begin
      check("rst_in_ready", W'(in_ready), W'(0));
      exp_q.delete();
      hold_v = 0;
    end else begin
      exp_rdy = (exp_q.size() < DEPTH) || ((exp_q.size() != 0) && wb_ready);
      check("wb_valid", W'(wb_valid), W'(exp_q.size() != 0));
      check("in_ready", W'(in_ready), W'(exp_rdy));
      if (!wb_valid) check("idle_gate", W'({wb_wreg, csr_we}), W'(0));
      if (hold_v && wb_valid) check("hold_stable", obs, hold_val);
      if (flush) begin
        exp_q.delete();
        hold_v = 0;
      end else begin
        if (wb_valid && wb_ready) begin
          if (exp_q.size() == 0) check("unexpected_pop", W'(1), W'(0));
          else                   check("pop_data", obs, exp_q.pop_front());
        end
        hold_v   = wb_valid && !wb_ready;
        hold_val = obs;
        if (in_valid && in_ready) exp_q.push_back(model());
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_rdy) wb_ready = 1'($urandom_range(0, 1));
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [4:0] a_wa, input logic a_wreg, input logic [63:0] a_dreg,
                        input logic a_mreg, input logic [1:0] a_size, input logic a_sign,
                        input logic [2:0] a_off, input logic [63:0] a_dm, input logic a_cwe,
                        input logic [11:0] a_cwa, input logic [63:0] a_cwd);
    in_wa = a_wa; in_wreg = a_wreg; in_dreg = a_dreg; in_mreg = a_mreg;
    in_size = a_size; in_sign = a_sign; in_offset = a_off; dm = a_dm;
    in_csr_we = a_cwe; in_csr_waddr = a_cwa; in_csr_wdata = a_cwd;
  endtask

  // Offers the current inputs until taken; returns just after the accept edge.
  task automatic send();
    logic acc;
    acc = 0;
    in_valid = 1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = in_ready && !flush;
      step();
    end
    in_valid = 0;
    if (!acc) check("send_timeout", W'(0), W'(1));
  endtask

  initial begin
    logic [1:0]  sz;
    logic [2:0]  off;
    logic [2:0]  amask;
    logic [11:0] cwa;

    repeat (3) step();
    reset = 0;
    @(negedge clock);
    check("rst_outputs", obs, W'(0));
    check("rst_valid", W'(wb_valid), W'(0));
    check("rst_ready_after", W'(in_ready), W'(1));
    step();

    // signed byte load from offset 4
    wb_ready = 1;
    set_in(5'd3, 1, 64'h0, 1, 2'd0, 1, 3'd4, 64'h8000_00F0_1234_5678, 0, 12'h0, 64'h0);
    send();
    @(negedge clock);
    check("lb_sign_wd", W'(wb_wd), W'(64'hFFFF_FFFF_FFFF_FFF0));
    check("lb_sign_wreg", W'(wb_wreg), W'(1));
    step();

    // misaligned halfword
    set_in(5'd4, 1, 64'h0, 1, 2'd1, 0, 3'd3, 64'h0123_4567_89AB_CDEF, 0, 12'h0, 64'h0);
    send();
    @(negedge clock);
    check("mis_flag", W'(wb_misalign), W'(1));
    check("mis_wreg", W'(wb_wreg), W'(0));
    check("mis_valid", W'(wb_valid), W'(1));
    step();
    @(negedge clock);
    check("mis_popped", W'(wb_valid), W'(0));
    step();

    // CSR writes
    set_in(5'd5, 0, 64'h11, 0, 2'd0, 0, 3'd0, 64'h0, 1, 12'h300, 64'h6000);
    send();
    @(negedge clock);
    check("mstatus_sd", W'(csr_wdata), W'(64'h8000_0000_0000_6000));
    check("mstatus_we", W'(csr_we), W'(1));
    step();
    set_in(5'd5, 0, 64'h11, 0, 2'd0, 0, 3'd0, 64'h0, 1, 12'h305, 64'h6000);
    send();
    @(negedge clock);
    check("other_csr", W'(csr_wdata), W'(64'h6000));
    step();

    // full FIFO: third push refused, then push and pop together
    wb_ready = 0;
    set_in(5'd6, 1, 64'hA, 0, 2'd0, 0, 3'd0, 64'h0, 0, 12'h0, 64'h0);
    send();
    set_in(5'd7, 1, 64'hB, 0, 2'd0, 0, 3'd0, 64'h0, 0, 12'h0, 64'h0);
    send();
    set_in(5'd8, 1, 64'hC, 0, 2'd0, 0, 3'd0, 64'h0, 0, 12'h0, 64'h0);
    in_valid = 1;
    @(negedge clock);
    check("full_refuse", W'(in_ready), W'(0));
    step();
    wb_ready = 1;
    @(negedge clock);
    check("full_pushpop_rdy", W'(in_ready), W'(1));
    step();
    in_valid = 0;
    wb_ready = 0;
    @(negedge clock);
    check("count_two", W'(in_ready), W'(0));
    check("order_head", W'(wb_wd), W'(64'hB));
    step();
    wb_ready = 1;
    step();
    step();
    @(negedge clock);
    check("full_drained", W'(wb_valid), W'(0));
    step();

    // flush with two entries and a concurrent push
    wb_ready = 0;
    set_in(5'd9, 1, 64'hD, 0, 2'd0, 0, 3'd0, 64'h0, 0, 12'h0, 64'h0);
    send();
    set_in(5'd10, 1, 64'hE, 0, 2'd0, 0, 3'd0, 64'h0, 0, 12'h0, 64'h0);
    send();
    set_in(5'd11, 1, 64'hF, 0, 2'd0, 0, 3'd0, 64'h0, 0, 12'h0, 64'h0);
    in_valid = 1;
    flush    = 1;
    wb_ready = 1;
    @(negedge clock);
    check("flush_push_offered", W'(in_ready), W'(1));
    step();
    flush    = 0;
    in_valid = 0;
    @(negedge clock);
    check("flush_empty", W'(wb_valid), W'(0));
    step();
    step();
    @(negedge clock);
    check("flush_no_ghost", W'(wb_valid), W'(0));
    step();

    // random traffic with random back-pressure
    rand_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      sz    = 2'($urandom_range(0, 3));
      off   = 3'($urandom_range(0, 7));
      amask = 3'((1 << sz) - 1);
      if ($urandom_range(0, 1) == 1) off = off & ~amask;
      case ($urandom_range(0, 2))
        0:       cwa = 12'h300;
        1:       cwa = 12'h305;
        default: cwa = 12'($urandom_range(0, 4095));
      endcase
      set_in(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
             1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), off,
             {$urandom, $urandom}, 1'($urandom_range(0, 1)), cwa, {$urandom, $urandom});
      send();
      repeat ($urandom_range(0, 2)) step();
    end
    rand_rdy = 0;
    step();
    wb_ready = 1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    @(negedge clock);
    check("rand_drained", W'(wb_valid), W'(0));
    step();

    // reset mid-stream with one entry held and a push offered
    wb_ready = 0;
    set_in(5'd12, 1, 64'h1234, 0, 2'd0, 0, 3'd0, 64'h0, 1, 12'h300, 64'h18000);
    send();
    set_in(5'd13, 1, 64'h5678, 0, 2'd0, 0, 3'd0, 64'h0, 1, 12'h301, 64'h1);
    in_valid = 1;
    reset    = 1;
    step();
    reset    = 0;
    in_valid = 0;
    @(negedge clock);
    check("midrst_outputs", obs, W'(0));
    check("midrst_valid", W'(wb_valid), W'(0));
    check("midrst_ready", W'(in_ready), W'(1));
    step();

    // write to x0 never writes back
    wb_ready = 1;
    set_in(5'd0, 1, 64'h99, 0, 2'd0, 0, 3'd0, 64'h0, 0, 12'h0, 64'h0);
    send();
    @(negedge clock);
    check("x0_valid", W'(wb_valid), W'(1));
    check("x0_wreg", W'(wb_wreg), W'(0));
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
